// File: rtl/tlk2711_rx_pattern_checker.sv
// Receive-side pattern checker for the TLK2711 rx FIFO read port.
// Three stages: input register, lane compare, then error/statistics outputs.
module tlk2711_rx_pattern_checker #(
    parameter int DATA_W = 64,
    parameter int LANE_W = 16,
    parameter int CNT_W  = 32,
    parameter int FLEN_W = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_soft_rst,
    input  logic                               i_valid,
    input  logic [DATA_W-1:0]                  i_data,
    input  logic                               i_check_ena,
    input  logic                               i_mode,
    input  logic [LANE_W-1:0]                  i_fixed_word,
    input  logic [FLEN_W-1:0]                  i_frame_beats,
    input  logic [$clog2(DATA_W/LANE_W):0]     i_last_lanes,
    input  logic                               i_clr_stats,
    output logic                               o_check_error,
    output logic                               o_err_sticky,
    output logic [CNT_W-1:0]                   o_err_cnt,
    output logic [CNT_W-1:0]                   o_frame_cnt,
    output logic [FLEN_W-1:0]                  o_first_err_beat,
    output logic [DATA_W-1:0]                  o_first_err_data
);

    localparam int LANES = DATA_W / LANE_W;
    localparam int NL_W  = $clog2(LANES) + 1;
    localparam logic [NL_W-1:0] LANES_N = NL_W'(LANES);

    function automatic logic [LANES-1:0][LANE_W-1:0] pat_start();
        logic [LANES-1:0][LANE_W-1:0] p;
        for (int k = 0; k < LANES; k++) begin
            p[k] = LANE_W'(LANES - 1 - k);
        end
        return p;
    endfunction

    logic reset_s;
    assign reset_s = rst | i_soft_rst;

    logic                          s1_valid_q, s1_ena_q, s1_mode_q;
    logic [DATA_W-1:0]             s1_data_q;
    logic [LANE_W-1:0]             s1_fixed_q;
    logic [FLEN_W-1:0]             beat_q, beat_d, len_q, len_d;
    logic [LANES-1:0][LANE_W-1:0]  pat_q, pat_d, exp_s;
    logic                          s2_err_q, s2_last_q;
    logic [FLEN_W-1:0]             s2_beat_q;
    logic [DATA_W-1:0]             s2_data_q;
    logic                          err_q, sticky_q, sticky_d;
    logic [CNT_W-1:0]              err_cnt_q, err_cnt_d, frame_cnt_q, frame_cnt_d, err_base_s;
    logic [FLEN_W-1:0]             first_beat_q, first_beat_d;
    logic [DATA_W-1:0]             first_data_q, first_data_d;
    logic                          acc_s, last_s, mism_s;
    logic [FLEN_W-1:0]             eff_len_s;
    logic [NL_W-1:0]               n_s;
    logic [LANES-1:0]              lane_bad_s;

    // Stage-1 compare: frame length pick-up, last-beat mask and lane mismatches
    always_comb begin
        acc_s = s1_valid_q & s1_ena_q;
        if (beat_q == '0) begin
            eff_len_s = (i_frame_beats == '0) ? FLEN_W'(1) : i_frame_beats;
        end else begin
            eff_len_s = len_q;
        end
        last_s = (beat_q == (eff_len_s - FLEN_W'(1)));
        if ((i_last_lanes == '0) || (i_last_lanes > LANES_N)) begin
            n_s = LANES_N;
        end else begin
            n_s = i_last_lanes;
        end
        for (int k = 0; k < LANES; k++) begin
            exp_s[k]      = s1_mode_q ? s1_fixed_q : pat_q[k];
            lane_bad_s[k] = (!last_s || (NL_W'(k) >= (LANES_N - n_s))) &&
                            (s1_data_q[k*LANE_W +: LANE_W] != exp_s[k]);
        end
        mism_s = acc_s & (|lane_bad_s);
    end

    // Beat counter, latched frame length and per-lane pattern accumulators
    always_comb begin
        beat_d = beat_q;
        len_d  = len_q;
        pat_d  = pat_q;
        if (!s1_ena_q) begin
            beat_d = '0;
            pat_d  = pat_start();
        end else if (acc_s) begin
            len_d = (beat_q == '0) ? eff_len_s : len_q;
            if (last_s) begin
                beat_d = '0;
                pat_d  = pat_start();
            end else begin
                beat_d = beat_q + FLEN_W'(1);
                for (int k = 0; k < LANES; k++) begin
                    pat_d[k] = pat_q[k] + LANE_W'(LANES);
                end
            end
        end else begin
            beat_d = beat_q;
        end
    end

    // Statistics; a mismatch arriving with a clear wins over the clear
    always_comb begin
        err_base_s  = i_clr_stats ? '0 : err_cnt_q;
        frame_cnt_d = (i_clr_stats ? '0 : frame_cnt_q) + {{(CNT_W-1){1'b0}}, s2_last_q};
        if (s2_err_q) begin
            err_cnt_d = (err_base_s == '1) ? err_base_s : err_base_s + CNT_W'(1);
            sticky_d  = 1'b1;
        end else begin
            err_cnt_d = err_base_s;
            sticky_d  = i_clr_stats ? 1'b0 : sticky_q;
        end
        if (s2_err_q && (i_clr_stats || !sticky_q)) begin
            first_beat_d = s2_beat_q;
            first_data_d = s2_data_q;
        end else if (i_clr_stats) begin
            first_beat_d = '0;
            first_data_d = '0;
        end else begin
            first_beat_d = first_beat_q;
            first_data_d = first_data_q;
        end
    end

    // Pipeline and state registers
    always_ff @(posedge clk) begin
        if (reset_s) begin
            s1_valid_q   <= 1'b0;
            s1_ena_q     <= 1'b0;
            s1_mode_q    <= 1'b0;
            s1_data_q    <= '0;
            s1_fixed_q   <= '0;
            beat_q       <= '0;
            len_q        <= '0;
            pat_q        <= pat_start();
            s2_err_q     <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_beat_q    <= '0;
            s2_data_q    <= '0;
            err_q        <= 1'b0;
            sticky_q     <= 1'b0;
            err_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            first_beat_q <= '0;
            first_data_q <= '0;
        end else begin
            s1_valid_q   <= i_valid;
            s1_ena_q     <= i_check_ena;
            s1_mode_q    <= i_mode;
            s1_data_q    <= i_data;
            s1_fixed_q   <= i_fixed_word;
            beat_q       <= beat_d;
            len_q        <= len_d;
            pat_q        <= pat_d;
            s2_err_q     <= mism_s;
            s2_last_q    <= acc_s & last_s;
            s2_beat_q    <= beat_q;
            s2_data_q    <= s1_data_q;
            err_q        <= s2_err_q;
            sticky_q     <= sticky_d;
            err_cnt_q    <= err_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            first_beat_q <= first_beat_d;
            first_data_q <= first_data_d;
        end
    end

    assign o_check_error    = err_q;
    assign o_err_sticky     = sticky_q;
    assign o_err_cnt        = err_cnt_q;
    assign o_frame_cnt      = frame_cnt_q;
    assign o_first_err_beat = first_beat_q;
    assign o_first_err_data = first_data_q;

endmodule

// File: doc/tlk2711_rx_pattern_checker.md
Name: tlk2711_rx_pattern_checker

Overview:
Parametrised checker for the TLK2711 receive path. It sits on the rx FIFO read side and checks each valid read beat against a locally generated reference pattern, on a frame-by-frame basis.
- Supports two pattern modes: per-lane incrementing counter, or a fixed fill word.
- Frame length and the number of valid lanes on the last beat are set at run time.
- Provides a per-beat error pulse, a sticky flag, a saturating error count, a frame count, and capture of the first failing beat, for register readback and ILA probing.

Parameters:
DATA_W, 64, read beat width in bits; must be a multiple of LANE_W.
LANE_W, 16, width of one pattern lane; LANES = DATA_W/LANE_W.
CNT_W, 32, width of the error and frame counters.
FLEN_W, 16, width of the frame length input (in beats).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_soft_rst  in  1  synchronous soft reset; same effect as rst
i_valid  in  1  i_data holds a valid FIFO read beat this cycle
i_data  in  DATA_W  FIFO read data; lane k = i_data[k*LANE_W +: LANE_W]
i_check_ena  in  1  checking enable; low = idle and resync to frame start
i_mode  in  1  0 = incrementing pattern, 1 = fixed word
i_fixed_word  in  LANE_W  expected value of every lane in fixed mode
i_frame_beats  in  FLEN_W  beats per frame; 0 treated as 1
i_last_lanes  in  clog2(LANES)+1  valid upper lanes on the last beat; 0 or >LANES treated as LANES
i_clr_stats  in  1  clears sticky flag, counters and capture; does not resync
o_check_error  out  1  one-cycle pulse per mismatching beat
o_err_sticky  out  1  set on any mismatch, held until cleared
o_err_cnt  out  CNT_W  mismatching beats, saturates at all-ones
o_frame_cnt  out  CNT_W  completed frames (last beat accepted), wraps
o_first_err_beat  out  FLEN_W  beat index of the first mismatch since clear
o_first_err_data  out  DATA_W  received data of the first mismatch since clear

Behaviour:
- Reset and clear:
  - rst or i_soft_rst: all outputs 0, beat counter 0, pipeline valid 0, pattern at frame start.
  - A reset in the middle of a frame discards all pipeline contents; no error pulse follows.
- Pipeline:
  - Stage 1 registers i_valid, i_data, i_check_ena, i_mode and i_fixed_word.
  - Stage 2 compares and registers the results.
  - A beat sampled at edge N drives o_check_error high after edge N+2, for one cycle only.
  - Counters and capture registers update on the same edge as o_check_error.
- Beat accounting:
  - Only stage-1 beats with valid and check_ena high are checked and advance the beat counter b.
  - Gaps in i_valid are transparent: pattern and b hold.
- Frame length:
  - The effective length L is latched from i_frame_beats when a beat with b == 0 is accepted; that beat already uses the new L.
  - i_frame_beats changes in the middle of a frame are ignored until the next frame.
- Last beat (b == L-1):
  - b returns to 0, o_frame_cnt increments, and the pattern reloads its start value.
  - When L == 1, every beat is a last beat.
- Incrementing mode, lane k (0 = LSB lane) expected value:
  - Formula: (LANES-1-k) + b*LANES, modulo 2^LANE_W.
  - Implement as a per-lane accumulator: start values LANES-1 down to 0, add LANES on each accepted beat.
  - With the defaults, beat 0 expects 64'h0000000100020003.
- Fixed mode: every lane expects i_fixed_word.
- Compare mask:
  - Non-last beats compare all lanes.
  - The last beat compares only the upper N = i_last_lanes lanes (LANES-N .. LANES-1); the lower lanes are don't-care.
- Check disable:
  - i_check_ena low (stage 1) forces b = 0 and reloads the pattern start values.
  - A beat in flight with i_check_ena low produces no error; this is the resync mechanism.
- On a mismatch:
  - o_check_error pulses and o_err_sticky is set.
  - o_err_cnt increments, saturating at all-ones.
  - If this is the first mismatch since reset or clear, o_first_err_beat = b and o_first_err_data = received data.
- The checker never resyncs on error: a slipped stream produces errors until i_check_ena toggles or the frame wraps.
- i_clr_stats:
  - Zeroes o_err_sticky, o_err_cnt, o_frame_cnt and the capture registers, and re-arms first-error capture.
  - If a mismatch occurs in the same cycle as the clear, the mismatch wins: sticky = 1, count = 1, and that beat is captured.
- A mismatch on the last beat is counted, and the frame still completes and increments o_frame_cnt.

Test Plan:
- Clean stream, defaults, L=109, N=3, mode 0, three frames back-to-back:
  - Stimulus: beat 1 = 64'h0004000500060007; beat 108 = 64'h01B001B101B2DEAD.
  - Required: o_check_error never asserts, o_frame_cnt=3, o_err_cnt=0.
- Beat 5 of frame 0, lane 0 flipped to 16'h0016:
  - Required: one o_check_error pulse exactly 2 cycles after that beat is sampled.
  - Required: o_err_cnt=1, sticky=1, o_first_err_beat=5, o_first_err_data=64'h0014001500160016.
  - Required: the following frame is clean.
- Random i_valid gaps (about 50% duty) on the clean stream:
  - Required: zero errors and o_frame_cnt increments once every 109 accepted beats.
- Mode 1, i_fixed_word=16'hA5A5, L=4, N=1:
  - Stimulus: last beat = 64'hA5A5000000000000.
  - Required: no error.
  - Stimulus: 64'hA5A4000000000000 on the last beat.
  - Required: error pulse, o_first_err_beat=3.
- Slip one beat mid-frame, then drop i_check_ena for one cycle and restart from beat 0:
  - Required: errors on every beat after the slip until the drop, zero errors after it.
  - Required: o_err_cnt equals the number of slipped beats.
- Reset and clear behaviour:
  - Stimulus: assert i_soft_rst mid-frame with an error in flight.
  - Required: all outputs 0, no late pulse.
  - Stimulus: i_clr_stats coincident with a mismatch.
  - Required: sticky=1, o_err_cnt=1, that beat captured.
  - Stimulus: force o_err_cnt to all-ones.
  - Required: o_err_cnt holds at all-ones.
